spi_slave_rx_tx: RTL and testbench
==================================

Name: spi_slave_rx_tx

Overview:
- SPI mode-0 (CPOL=0, CPHA=0), MSB-first target device: the other end of our in-house SPI master.
- Oversamples spi_clk, spi_cs_n and spi_mosi on clk through synchronisers.
- Shifts in received words and presents each completed word with a 1-cycle rx_valid pulse.
- Shifts out a word supplied through a single-entry valid/ready holding register; supports back-to-back words while spi_cs_n stays low.

Parameters:
- DATA_W, 8: bits per SPI word.
- SYNC_STAGES, 2: synchroniser flops on each SPI input (minimum 2).
- IDLE_WORD, 8'hFF: word driven on MISO when no tx word is held (underrun).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- spi_clk  in  1  SCLK from master; idle low.
- spi_cs_n  in  1  chip select, active-low.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO tristate enable; high only while selected.
- tx_data  in  DATA_W  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register empty.
- rx_data  out  DATA_W  last completed received word.
- rx_valid  out  1  1-cycle pulse: rx_data updated.
- tx_underrun  out  1  1-cycle pulse: IDLE_WORD committed because the holding register was empty.
- busy  out  1  state is ACTIVE.

Behaviour:
- Reset (async):
  - Synchroniser resets: sclk=0, cs_n=1, mosi=0.
  - state=IDLE, bit_cnt=0.
  - spi_miso=0, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0; holding register empty.
- Edge detection: compare the last synchroniser stage with its previous value, giving sclk_rise, sclk_fall, cs_fall and cs_rise.
- Timing constraints on the master:
  - SCLK high and low phases each ≥ SYNC_STAGES+2 clk.
  - cs_n low to first SCLK rise ≥ SYNC_STAGES+2 clk.
- Holding register:
  - Accept on tx_valid && tx_ready; tx_ready=0 from the next cycle.
  - Freed only on commit; tx_ready=1 the cycle after commit.
- Preview (cs_fall, or sclk_fall with bit_cnt==0 in ACTIVE):
  - spi_miso <= MSB of the holding register if full, else IDLE_WORD[DATA_W-1].
  - Latch flag from_hold = (register full).
- Commit (sclk_rise with bit_cnt==0):
  - tx_shift <= from_hold ? holding register : IDLE_WORD.
  - If from_hold, free the register; else pulse tx_underrun.
  - A word accepted between preview and commit is not used and stays held for the next word.
- State machine:
  - IDLE:
    - spi_miso_oe=0, bit_cnt=0.
    - cs_fall -> ACTIVE, preview.
  - ACTIVE:
    - spi_miso_oe=1.
    - sclk_rise: rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}; commit if bit_cnt==0.
    - If bit_cnt==DATA_W-1: rx_data <= completed word, rx_valid=1 next cycle, bit_cnt <= 0; else bit_cnt++.
    - sclk_fall, bit_cnt≠0: spi_miso <= tx_shift[DATA_W-1-bit_cnt].
    - sclk_fall, bit_cnt==0: preview of the next word.
    - cs_rise -> IDLE from any bit position.
- Abort on cs_rise:
  - Partial rx word discarded (no rx_valid).
  - A committed tx word is lost; a previewed-but-uncommitted held word remains held.
  - spi_miso_oe=0 next cycle.
- Simultaneous sclk_rise and cs_rise: cs_rise wins; no sample.
- SCLK edges while IDLE are ignored.
- Latency:
  - spi_miso updates SYNC_STAGES+1 clk after the pin edge of SCLK fall or cs_n fall.
  - rx_valid asserts SYNC_STAGES+2 clk after the pin edge of the last SCLK rise.
- rx path has no backpressure; each new word overwrites rx_data.
- rst_n mid-transfer returns everything to reset values immediately.

Test Plan:
- Single byte: load tx 8'hA5; master sends 8'h3C at SCLK = clk/8 -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C with one rx_valid pulse; tx_ready high after the first SCLK rise.
- Back-to-back: load 8'h12, then 8'h34 once tx_ready rises; master sends 8'hF0, 8'h0F under one cs_n low -> MISO words 8'h12, 8'h34; two rx_valid pulses with 8'hF0, 8'h0F.
- Underrun: no tx word loaded; master sends 8'h55 -> MISO carries 8'hFF; tx_underrun pulses once at the first SCLK rise; rx_data=8'h55.
- Abort: cs_n raised after 4 SCLK rises -> no rx_valid; spi_miso_oe=0; busy=0; next full transfer of 8'h81 yields rx_data=8'h81.
- Late load: tx_valid with 8'hC3 asserted between cs_n fall and the first SCLK rise while the register is empty -> word 0 transmits 8'hFF with underrun; word 1 transmits 8'hC3.
- Reset mid-transfer: rst_n pulsed low after 3 bits -> all outputs at reset values; tx_ready=1; following transfer of 8'h7E is received correctly.

Source files
------------

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 target (CPOL=0, CPHA=0, MSB first), oversampled on clk.
// Received words are presented on rx_data with a single-cycle rx_valid.
// Transmit words come through a single-entry valid/ready holding register.
// When that register is empty at the start of a word, IDLE_WORD is sent
// instead and tx_underrun pulses.
module spi_slave_rx_tx #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_WORD   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);
    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      rx_shift_q, rx_shift_d;
    logic                   word_done_q, word_done_d;
    logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   from_hold_q, from_hold_d;
    logic                   miso_q, miso_d;
    logic                   oe_q, busy_q, tx_ready_q;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   underrun_q, underrun_d;

    // Synchronise the SPI pins and keep the previous last-stage value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= {SYNC_STAGES{1'b0}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_s & sclk_prev_q;
    assign cs_fall_s   = ~cs_s & cs_prev_q;
    assign cs_rise_s   = cs_s & ~cs_prev_q;

    // Next-state logic: FSM, shift registers, holding register and output pulses.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        word_done_d = 1'b0;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        from_hold_d = from_hold_q;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;

        // The completed word was captured one cycle earlier; publish it now.
        if (word_done_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end else begin
            rx_valid_d = 1'b0;
        end

        // Accepting and freeing are mutually exclusive: commit frees only a full register.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end else begin
            hold_d = hold_q;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d = {CNT_W{1'b0}};
                if (cs_fall_s) begin
                    state_d     = ACTIVE;
                    miso_d      = hold_full_q ? hold_q[DATA_W-1] : IDLE_WORD[DATA_W-1];
                    from_hold_d = hold_full_q;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (cs_rise_s) begin
                    // Abort: the partial rx word is dropped; a previewed word stays held.
                    state_d   = IDLE;
                    bit_cnt_d = {CNT_W{1'b0}};
                end else if (sclk_rise_s) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q == {CNT_W{1'b0}}) begin
                        // Commit: the word chosen at preview time is the one shifted out.
                        tx_shift_d = from_hold_q ? hold_q : IDLE_WORD;
                        if (from_hold_q) begin
                            hold_full_d = 1'b0;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end else begin
                        tx_shift_d = tx_shift_q;
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        word_done_d = 1'b1;
                        bit_cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall_s) begin
                    if (bit_cnt_q == {CNT_W{1'b0}}) begin
                        miso_d      = hold_full_q ? hold_q[DATA_W-1] : IDLE_WORD[DATA_W-1];
                        from_hold_d = hold_full_q;
                    end else begin
                        // MSB already went out at preview; walk the rest down the shifter.
                        miso_d     = tx_shift_q[DATA_W-2];
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    state_d = ACTIVE;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= {CNT_W{1'b0}};
            rx_shift_q  <= {DATA_W{1'b0}};
            word_done_q <= 1'b0;
            tx_shift_q  <= {DATA_W{1'b0}};
            hold_q      <= {DATA_W{1'b0}};
            hold_full_q <= 1'b0;
            from_hold_q <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            tx_ready_q  <= 1'b1;
            rx_data_q   <= {DATA_W{1'b0}};
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            word_done_q <= word_done_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            from_hold_q <= from_hold_d;
            miso_q      <= miso_d;
            oe_q        <= (state_d == ACTIVE);
            busy_q      <= (state_d == ACTIVE);
            tx_ready_q  <= ~hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign busy        = busy_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Bench for spi_slave_rx_tx: a bit-level SPI master drives directed and
// random transfers; a word-level model predicts MISO words, rx words and
// underrun pulses, and a per-cycle compare process checks the DUT.
module tb_spi_slave_rx_tx;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_clk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, tx_underrun, busy;

    spi_slave_rx_tx #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_WORD(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // model state
    bit         m_held = 1'b0;
    logic [7:0] m_hold = 8'h00;
    int         m_under = 0;
    logic [7:0] rx_exp[$];
    int         und_seen = 0;
    int         rxv_seen = 0;

    // transfer description
    logic [7:0] x_words[4];
    logic [7:0] x_nxt[4];
    bit         x_ldn[4];
    logic [7:0] last_words[4];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [7:0] d);
        chk("tx_ready_before_load", {31'd0, tx_ready}, {31'd0, !m_held});
        tx_data  = d;
        tx_valid = 1'b1;
        tick_n(1);
        tx_valid = 1'b0;
        m_held   = 1'b1;
        m_hold   = d;
    endtask

    // One chip-select period of nw words; optional abort in word ab_w after ab_k rises,
    // optional late load after cs fall but before the first rise.
    task automatic xfer(input int nw, input int ab_w, input int ab_k, input bit late, input logic [7:0] late_d);
        logic [7:0] got;
        logic [7:0] exp_w;
        logic [7:0] mask;
        bit         use_hold;
        bit         aborted;
        aborted  = 1'b0;
        got      = 8'h00;
        spi_mosi = x_words[0][7];
        spi_cs_n = 1'b0;
        use_hold = m_held;
        exp_w    = m_held ? m_hold : 8'hFF;
        if (late) begin
            tick_n(4);
            load(late_d);
            tick_n(1);
        end else begin
            tick_n(6);
        end
        for (int w = 0; w < nw && !aborted; w++) begin
            got = 8'h00;
            for (int r = 0; r < 8; r++) begin
                if (w == ab_w && r == ab_k) begin
                    aborted = 1'b1;
                    break;
                end
                if (r > 0 || w > 0) begin
                    spi_mosi = x_words[w][7-r];
                    if (r == 1 && x_ldn[w] && !m_held) begin
                        tick_n(1);
                        load(x_nxt[w]);
                        tick_n(H - 2);
                    end else begin
                        tick_n(H);
                    end
                end
                got[7-r] = spi_miso;
                spi_clk  = 1'b1;
                if (r == 0) begin
                    if (use_hold) m_held = 1'b0;
                    else m_under++;
                end
                if (r == 7) rx_exp.push_back(x_words[w]);
                tick_n(H);
                spi_clk = 1'b0;
                if (r == 7) begin
                    chk("miso_word", {24'd0, got}, {24'd0, exp_w});
                    last_words[w] = got;
                    use_hold = m_held;
                    exp_w    = m_held ? m_hold : 8'hFF;
                end
            end
        end
        if (aborted && ab_k > 0) begin
            mask = ~(8'hFF >> ab_k);
            chk("miso_partial", {24'd0, got & mask}, {24'd0, exp_w & mask});
        end
        tick_n(H);
        spi_cs_n = 1'b1;
        tick_n(8);
    endtask

    task automatic clear_x();
        for (int i = 0; i < 4; i++) begin
            x_ldn[i] = 1'b0;
            x_nxt[i] = 8'h00;
        end
    endtask

    // Per-cycle compare against the model.
    bit   prev_rxv = 1'b0;
    int   cs_hi_cnt = 0;
    int   cs_lo_cnt = 0;
    logic [7:0] rx_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                rxv_seen++;
                if (rx_exp.size() == 0) begin
                    chk("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    rx_e = rx_exp.pop_front();
                    chk("rx_word", {24'd0, rx_data}, {24'd0, rx_e});
                end
                chk("rx_pulse_width", {31'd0, prev_rxv}, 32'd0);
            end
            if (tx_underrun) begin
                und_seen++;
                chk("underrun_expected", {31'd0, (m_under > 0)}, 32'd1);
                if (m_under > 0) m_under--;
            end
            if (cs_hi_cnt >= 4) chk("idle_oe_busy", {30'd0, spi_miso_oe, busy}, 32'd0);
            if (cs_lo_cnt >= 4) chk("active_oe_busy", {30'd0, spi_miso_oe, busy}, 32'd3);
            if (spi_cs_n) begin
                cs_hi_cnt++;
                cs_lo_cnt = 0;
            end else begin
                cs_lo_cnt++;
                cs_hi_cnt = 0;
            end
        end else begin
            cs_hi_cnt = 0;
            cs_lo_cnt = 0;
        end
        prev_rxv = rx_valid;
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_miso"}, {31'd0, spi_miso}, 32'd0);
        chk({tag, "_oe"}, {31'd0, spi_miso_oe}, 32'd0);
        chk({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
        chk({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        chk({tag, "_underrun"}, {31'd0, tx_underrun}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int u0;
        int r0;
        int nw, abw, abk;
        bit late;
        clear_x();
        tick_n(3);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick_n(4);

        // single byte
        load(8'hA5);
        x_words[0] = 8'h3C;
        xfer(1, 99, 0, 1'b0, 8'h00);
        chk("single_miso", {24'd0, last_words[0]}, 32'h0000_00A5);
        chk("single_rx", {24'd0, rx_data}, 32'h0000_003C);
        chk("single_tx_ready", {31'd0, tx_ready}, 32'd1);

        // back-to-back
        load(8'h12);
        x_words[0] = 8'hF0; x_words[1] = 8'h0F;
        x_ldn[0] = 1'b1; x_nxt[0] = 8'h34;
        r0 = rxv_seen;
        xfer(2, 99, 0, 1'b0, 8'h00);
        clear_x();
        chk("b2b_w0", {24'd0, last_words[0]}, 32'h0000_0012);
        chk("b2b_w1", {24'd0, last_words[1]}, 32'h0000_0034);
        chk("b2b_rx_cnt", rxv_seen - r0, 32'd2);
        chk("b2b_rx_last", {24'd0, rx_data}, 32'h0000_000F);

        // underrun
        u0 = und_seen;
        x_words[0] = 8'h55;
        xfer(1, 99, 0, 1'b0, 8'h00);
        chk("underrun_miso", {24'd0, last_words[0]}, 32'h0000_00FF);
        chk("underrun_cnt", und_seen - u0, 32'd1);
        chk("underrun_rx", {24'd0, rx_data}, 32'h0000_0055);

        // abort after 4 rises
        r0 = rxv_seen;
        x_words[0] = 8'hC6;
        xfer(1, 0, 4, 1'b0, 8'h00);
        chk("abort_no_rx", rxv_seen - r0, 32'd0);
        chk("abort_oe_busy", {30'd0, spi_miso_oe, busy}, 32'd0);
        x_words[0] = 8'h81;
        xfer(1, 99, 0, 1'b0, 8'h00);
        chk("abort_next_rx", {24'd0, rx_data}, 32'h0000_0081);

        // late load
        u0 = und_seen;
        x_words[0] = 8'h11; x_words[1] = 8'h22;
        xfer(2, 99, 0, 1'b1, 8'hC3);
        chk("late_w0", {24'd0, last_words[0]}, 32'h0000_00FF);
        chk("late_w1", {24'd0, last_words[1]}, 32'h0000_00C3);
        chk("late_underrun_cnt", und_seen - u0, 32'd1);

        // reset mid-transfer
        spi_cs_n = 1'b0;
        spi_mosi = 1'b1;
        tick_n(6);
        for (int r = 0; r < 3; r++) begin
            spi_clk = 1'b1;
            if (r == 0) begin
                if (m_held) m_held = 1'b0;
                else m_under++;
            end
            tick_n(H);
            spi_clk = 1'b0;
            tick_n(H);
        end
        load(8'h99);
        rst_n = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        m_held = 1'b0;
        m_under = 0;
        rx_exp.delete();
        tick_n(3);
        rst_n = 1'b1;
        tick_n(4);
        chk("post_reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        x_words[0] = 8'h7E;
        xfer(1, 99, 0, 1'b0, 8'h00);
        chk("post_reset_rx", {24'd0, rx_data}, 32'h0000_007E);

        // random transfers
        for (int t = 0; t < 40; t++) begin
            clear_x();
            nw = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) begin
                x_words[i] = 8'($urandom);
                x_ldn[i]   = 1'($urandom);
                x_nxt[i]   = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                abw = $urandom_range(0, nw - 1);
                abk = $urandom_range(0, 7);
            end else begin
                abw = 99;
                abk = 0;
            end
            late = 1'b0;
            if (!m_held) begin
                case ($urandom_range(0, 4))
                    0: late = 1'b1;
                    1, 2: load(8'($urandom));
                    default: late = 1'b0;
                endcase
            end
            xfer(nw, abw, abk, late, 8'($urandom));
        end

        tick_n(20);
        chk("rx_queue_drained", rx_exp.size(), 32'd0);
        chk("underrun_drained", m_under, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
